// File: rtl/memory_map_pkg.sv
// Shared constants for the memory map: bank select codes, register addresses
// and the port and bank geometry used by the top level and its RAM instances.
package memory_map_pkg;

    typedef enum logic [1:0] {
        SelCtrl = 2'd0,
        SelMod  = 2'd1,
        SelDuty = 2'd2,
        SelStm  = 2'd3
    } bram_sel_e;

    localparam logic [7:0] AddrModWrSegment = 8'h20;
    localparam logic [7:0] AddrStmWrSegment = 8'h21;
    localparam logic [7:0] AddrStmWrPage    = 8'h22;

    localparam int unsigned HostAddrW = 14;
    localparam int unsigned HostDataW = 16;
    localparam int unsigned CtrlAddrW = 8;
    localparam int unsigned ModIdxW   = 15;
    localparam int unsigned DutyIdxW  = 15;
    localparam int unsigned StmAddrW  = 14;
    localparam int unsigned StmDataW  = 64;
    localparam int unsigned ByteW     = 8;

    // Word-address widths of each bank on the host (16-bit) side
    localparam int unsigned CtrlWordAw = 8;
    localparam int unsigned ModWordAw  = 15;
    localparam int unsigned DutyWordAw = 14;
    localparam int unsigned StmWordAw  = 17;

    localparam int unsigned CtrlDepth = 1 << CtrlWordAw;
    localparam int unsigned ModDepth  = 1 << ModWordAw;
    localparam int unsigned DutyDepth = 1 << DutyWordAw;
    localparam int unsigned StmDepth  = 1 << StmWordAw;

endpackage

// File: rtl/bram_dp.sv
// Dual-port RAM with independent port widths, read-first behaviour and a
// two-register read pipeline on both ports. Port A wins on a same-cycle write collision.
module bram_dp #(
    parameter int unsigned WidthA     = 16,
    parameter int unsigned AddrWidthA = 8,
    parameter int unsigned WidthB     = 16,
    parameter int unsigned AddrWidthB = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_a_i,
    input  logic [AddrWidthA-1:0] addr_a_i,
    input  logic [WidthA-1:0]     din_a_i,
    output logic [WidthA-1:0]     dout_a_o,
    input  logic                  we_b_i,
    input  logic [AddrWidthB-1:0] addr_b_i,
    input  logic [WidthB-1:0]     din_b_i,
    output logic [WidthB-1:0]     dout_b_o
);

    // Storage is kept in units of the narrower port; the wider port spans several units
    localparam int unsigned UnitW  = (WidthA < WidthB) ? WidthA : WidthB;
    localparam int unsigned RatioA = WidthA / UnitW;
    localparam int unsigned RatioB = WidthB / UnitW;
    localparam int unsigned Depth  = (1 << AddrWidthA) * RatioA;
    localparam int unsigned IdxW   = $clog2(Depth);

    logic [UnitW-1:0]  mem_q [Depth];
    logic [IdxW-1:0]   idx_a [RatioA];
    logic [IdxW-1:0]   idx_b [RatioB];
    logic [WidthA-1:0] rd_a_d, rd_a_q, dout_a_q;
    logic [WidthB-1:0] rd_b_d, rd_b_q, dout_b_q;

    always_comb begin
        rd_a_d = '0;
        for (int unsigned i = 0; i < RatioA; i++) begin
            idx_a[i] = IdxW'(32'(addr_a_i) * RatioA + i);
            rd_a_d[i*UnitW +: UnitW] = mem_q[idx_a[i]];
        end
    end

    always_comb begin
        rd_b_d = '0;
        for (int unsigned j = 0; j < RatioB; j++) begin
            idx_b[j] = IdxW'(32'(addr_b_i) * RatioB + j);
            rd_b_d[j*UnitW +: UnitW] = mem_q[idx_b[j]];
        end
    end

    // Port A is written last so its value survives a collision with port B
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (we_b_i) begin
                for (int unsigned j = 0; j < RatioB; j++) begin
                    mem_q[idx_b[j]] <= din_b_i[j*UnitW +: UnitW];
                end
            end
            if (we_a_i) begin
                for (int unsigned i = 0; i < RatioA; i++) begin
                    mem_q[idx_a[i]] <= din_a_i[i*UnitW +: UnitW];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_a_q   <= '0;
            dout_a_q <= '0;
            rd_b_q   <= '0;
            dout_b_q <= '0;
        end else begin
            rd_a_q   <= rd_a_d;
            dout_a_q <= rd_a_q;
            rd_b_q   <= rd_b_d;
            dout_b_q <= rd_b_q;
        end
    end

    assign dout_a_o = dout_a_q;
    assign dout_b_o = dout_b_q;

endmodule

// File: rtl/memory_map.sv
// Host-visible memory map: controller register bank, modulation, duty-table and
// STM banks, with write-segment/page latches held in the controller bank.
module memory_map
    import memory_map_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_en_i,
    input  logic                 mem_we_i,
    input  logic [1:0]           mem_bram_select_i,
    input  logic [HostAddrW-1:0] mem_addr_i,
    input  logic [HostDataW-1:0] mem_data_in_i,
    output logic [HostDataW-1:0] mem_data_out_o,
    input  logic                 cnt_we_i,
    input  logic [CtrlAddrW-1:0] cnt_addr_i,
    input  logic [HostDataW-1:0] cnt_din_i,
    output logic [HostDataW-1:0] cnt_dout_o,
    input  logic                 mod_segment_i,
    input  logic [ModIdxW-1:0]   mod_idx_i,
    output logic [ByteW-1:0]     mod_value_o,
    input  logic                 stm_segment_i,
    input  logic [StmAddrW-1:0]  stm_addr_i,
    output logic [StmDataW-1:0]  stm_data_o,
    input  logic [DutyIdxW-1:0]  duty_idx_i,
    output logic [ByteW-1:0]     duty_value_o
);

    bram_sel_e sel;
    logic      host_wr, host_rd;
    logic      we_ctrl, we_mod, we_duty, we_stm;

    logic       mod_wr_segment_d, mod_wr_segment_q;
    logic       stm_wr_segment_d, stm_wr_segment_q;
    logic [1:0] stm_wr_page_d, stm_wr_page_q;

    logic                 rd1_q, rd2_q, ctrl1_q, ctrl2_q;
    logic [HostDataW-1:0] hold_q, data_out;
    logic [HostDataW-1:0] ctrl_rdata, mod_rdata, duty_rdata, stm_rdata;
    logic                 unused_rdata;

    assign sel     = bram_sel_e'(mem_bram_select_i);
    assign host_wr = mem_en_i & mem_we_i;
    assign host_rd = mem_en_i & ~mem_we_i;
    assign we_ctrl = host_wr & (sel == SelCtrl);
    assign we_mod  = host_wr & (sel == SelMod);
    assign we_duty = host_wr & (sel == SelDuty);
    assign we_stm  = host_wr & (sel == SelStm);

    always_comb begin
        mod_wr_segment_d = mod_wr_segment_q;
        stm_wr_segment_d = stm_wr_segment_q;
        stm_wr_page_d    = stm_wr_page_q;
        if (we_ctrl) begin
            case (mem_addr_i[CtrlAddrW-1:0])
                AddrModWrSegment: mod_wr_segment_d = mem_data_in_i[0];
                AddrStmWrSegment: stm_wr_segment_d = mem_data_in_i[0];
                AddrStmWrPage:    stm_wr_page_d    = mem_data_in_i[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mod_wr_segment_q <= 1'b0;
            stm_wr_segment_q <= 1'b0;
            stm_wr_page_q    <= 2'd0;
            rd1_q            <= 1'b0;
            rd2_q            <= 1'b0;
            ctrl1_q          <= 1'b0;
            ctrl2_q          <= 1'b0;
            hold_q           <= '0;
        end else begin
            mod_wr_segment_q <= mod_wr_segment_d;
            stm_wr_segment_q <= stm_wr_segment_d;
            stm_wr_page_q    <= stm_wr_page_d;
            rd1_q            <= host_rd;
            rd2_q            <= rd1_q;
            ctrl1_q          <= (sel == SelCtrl);
            ctrl2_q          <= ctrl1_q;
            hold_q           <= data_out;
        end
    end

    // Host reads track the RAM pipeline; anything other than a read keeps the last value
    always_comb begin
        data_out = hold_q;
        if (rd2_q) begin
            data_out = ctrl2_q ? ctrl_rdata : '0;
        end
    end

    assign mem_data_out_o = data_out;

    bram_dp #(
        .WidthA     (HostDataW),
        .AddrWidthA (CtrlWordAw),
        .WidthB     (HostDataW),
        .AddrWidthB (CtrlAddrW)
    ) u_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_a_i   (we_ctrl),
        .addr_a_i (mem_addr_i[CtrlAddrW-1:0]),
        .din_a_i  (mem_data_in_i),
        .dout_a_o (ctrl_rdata),
        .we_b_i   (cnt_we_i),
        .addr_b_i (cnt_addr_i),
        .din_b_i  (cnt_din_i),
        .dout_b_o (cnt_dout_o)
    );

    bram_dp #(
        .WidthA     (HostDataW),
        .AddrWidthA (ModWordAw),
        .WidthB     (ByteW),
        .AddrWidthB (ModIdxW + 1)
    ) u_mod (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_a_i   (we_mod),
        .addr_a_i ({mod_wr_segment_q, mem_addr_i}),
        .din_a_i  (mem_data_in_i),
        .dout_a_o (mod_rdata),
        .we_b_i   (1'b0),
        .addr_b_i ({mod_segment_i, mod_idx_i}),
        .din_b_i  ({ByteW{1'b0}}),
        .dout_b_o (mod_value_o)
    );

    bram_dp #(
        .WidthA     (HostDataW),
        .AddrWidthA (DutyWordAw),
        .WidthB     (ByteW),
        .AddrWidthB (DutyIdxW)
    ) u_duty (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_a_i   (we_duty),
        .addr_a_i (mem_addr_i),
        .din_a_i  (mem_data_in_i),
        .dout_a_o (duty_rdata),
        .we_b_i   (1'b0),
        .addr_b_i (duty_idx_i),
        .din_b_i  ({ByteW{1'b0}}),
        .dout_b_o (duty_value_o)
    );

    bram_dp #(
        .WidthA     (HostDataW),
        .AddrWidthA (StmWordAw),
        .WidthB     (StmDataW),
        .AddrWidthB (StmAddrW + 1)
    ) u_stm (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_a_i   (we_stm),
        .addr_a_i ({stm_wr_segment_q, stm_wr_page_q, mem_addr_i}),
        .din_a_i  (mem_data_in_i),
        .dout_a_o (stm_rdata),
        .we_b_i   (1'b0),
        .addr_b_i ({stm_segment_i, stm_addr_i}),
        .din_b_i  ({StmDataW{1'b0}}),
        .dout_b_o (stm_data_o)
    );

    // Only the controller bank is readable from the host side
    assign unused_rdata = ^{mod_rdata, duty_rdata, stm_rdata};

endmodule

// File: tb/tb_memory_map.sv
// Self-checking bench for memory_map: directed scenarios plus randomized
// bank traffic compared against a flat-array model of the memory map.
module tb_memory_map;

    logic        clk, rst;
    logic        mem_en, mem_we;
    logic [1:0]  mem_sel;
    logic [13:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic        cnt_we;
    logic [7:0]  cnt_addr;
    logic [15:0] cnt_din, cnt_dout;
    logic        mod_seg;
    logic [14:0] mod_idx;
    logic [7:0]  mod_value;
    logic        stm_seg;
    logic [13:0] stm_addr;
    logic [63:0] stm_data;
    logic [14:0] duty_idx;
    logic [7:0]  duty_value;

    int checks = 0;
    int errors = 0;

    // Model: flat word arrays addressed by plain arithmetic, plus the three latches
    logic [15:0] ctrl_m [int];
    logic [15:0] mod_m  [int];
    logic [15:0] duty_m [int];
    logic [15:0] stm_m  [int];
    int m_mod_seg = 0, m_stm_seg = 0, m_stm_page = 0;

    memory_map dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .mem_en_i          (mem_en),
        .mem_we_i          (mem_we),
        .mem_bram_select_i (mem_sel),
        .mem_addr_i        (mem_addr),
        .mem_data_in_i     (mem_din),
        .mem_data_out_o    (mem_dout),
        .cnt_we_i          (cnt_we),
        .cnt_addr_i        (cnt_addr),
        .cnt_din_i         (cnt_din),
        .cnt_dout_o        (cnt_dout),
        .mod_segment_i     (mod_seg),
        .mod_idx_i         (mod_idx),
        .mod_value_o       (mod_value),
        .stm_segment_i     (stm_seg),
        .stm_addr_i        (stm_addr),
        .stm_data_o        (stm_data),
        .duty_idx_i        (duty_idx),
        .duty_value_o      (duty_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int bank, input int key);
        case (bank)
            0: return ctrl_m.exists(key) ? ctrl_m[key] : 16'h0000;
            1: return mod_m.exists(key) ? mod_m[key] : 16'h0000;
            2: return duty_m.exists(key) ? duty_m[key] : 16'h0000;
            default: return stm_m.exists(key) ? stm_m[key] : 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] w, input int idx);
        return (idx % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    function automatic void model_write(input int sel, input int addr, input logic [15:0] d);
        case (sel)
            0: begin
                ctrl_m[addr % 256] = d;
                if (addr % 256 == 32) m_mod_seg = int'(d[0]);
                if (addr % 256 == 33) m_stm_seg = int'(d[0]);
                if (addr % 256 == 34) m_stm_page = int'(d[1:0]);
            end
            1: mod_m[m_mod_seg * 16384 + addr] = d;
            2: duty_m[addr] = d;
            default: stm_m[m_stm_seg * 65536 + m_stm_page * 16384 + addr] = d;
        endcase
    endfunction

    task automatic host_write(input int sel, input int addr, input logic [15:0] d);
        mem_en = 1'b1; mem_we = 1'b1; mem_sel = 2'(sel); mem_addr = 14'(addr); mem_din = d;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_we = 1'b0;
        model_write(sel, addr, d);
    endtask

    task automatic chk_host(input int sel, input int addr, input string tag);
        mem_en = 1'b1; mem_we = 1'b0; mem_sel = 2'(sel); mem_addr = 14'(addr);
        @(posedge clk); #1;
        mem_en = 1'b0;
        @(posedge clk); #1;
        chk(tag, 64'(mem_dout), 64'((sel == 0) ? word_of(0, addr % 256) : 16'h0000));
    endtask

    task automatic chk_cnt(input int addr, input string tag);
        cnt_addr = 8'(addr);
        @(posedge clk); @(posedge clk); #1;
        chk(tag, 64'(cnt_dout), 64'(word_of(0, addr)));
    endtask

    task automatic chk_mod(input int seg, input int idx, input string tag);
        mod_seg = 1'(seg); mod_idx = 15'(idx);
        @(posedge clk); @(posedge clk); #1;
        chk(tag, 64'(mod_value), 64'(byte_of(word_of(1, seg * 16384 + idx / 2), idx)));
    endtask

    task automatic chk_duty(input int idx, input string tag);
        duty_idx = 15'(idx);
        @(posedge clk); @(posedge clk); #1;
        chk(tag, 64'(duty_value), 64'(byte_of(word_of(2, idx / 2), idx)));
    endtask

    task automatic chk_stm(input int seg, input int entry, input logic [63:0] mask,
                           input string tag);
        logic [63:0] exp;
        stm_seg = 1'(seg); stm_addr = 14'(entry);
        for (int k = 0; k < 4; k++) exp[16*k +: 16] = word_of(3, seg * 65536 + entry * 4 + k);
        @(posedge clk); @(posedge clk); #1;
        chk(tag, stm_data & mask, exp & mask);
    endtask

    initial begin
        logic [63:0] entry;
        logic [15:0] d;
        int a, base, kind;

        rst = 1'b1;
        mem_en = 1'b0; mem_we = 1'b0; mem_sel = 2'd0; mem_addr = '0; mem_din = '0;
        cnt_we = 1'b0; cnt_addr = '0; cnt_din = '0;
        mod_seg = 1'b0; mod_idx = '0; stm_seg = 1'b0; stm_addr = '0; duty_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 64'(mem_dout), 64'h0);
        chk("rst_cnt_dout", 64'(cnt_dout), 64'h0);
        chk("rst_mod_value", 64'(mod_value), 64'h0);
        chk("rst_stm_data", stm_data, 64'h0);
        chk("rst_duty_value", 64'(duty_value), 64'h0);
        rst = 1'b0;

        // Focus entry into STM segment 1, page 0, entry 3
        host_write(0, 'h21, 16'h0001);
        host_write(0, 'h22, 16'h0000);
        entry = {2'b00, 8'hA5, 18'(131071), 18'(-2000), 18'(1000)};
        for (int k = 0; k < 4; k++) host_write(3, 12 + k, entry[16*k +: 16]);
        chk_stm(1, 3, '1, "stm_focus_model");
        chk("stm_focus_packed", stm_data, entry);

        // Page 2 write lands at entry 8192; page-0 word untouched
        host_write(0, 'h21, 16'h0000);
        host_write(3, 0, 16'h7777);
        host_write(0, 'h22, 16'h0002);
        host_write(3, 0, 16'h1234);
        chk_stm(0, 8192, 64'hFFFF, "stm_page2");
        chk("stm_page2_const", 64'(stm_data[15:0]), 64'h1234);
        chk_stm(0, 0, 64'hFFFF, "stm_page0_kept");

        // Modulation byte ordering and segment isolation
        host_write(0, 'h20, 16'h0001);
        host_write(1, 5, 16'hCAFE);
        host_write(0, 'h20, 16'h0000);
        host_write(1, 5, 16'hBEEF);
        chk_mod(0, 10, "mod_lo");
        chk("mod_lo_const", 64'(mod_value), 64'hEF);
        chk_mod(0, 11, "mod_hi");
        chk("mod_hi_const", 64'(mod_value), 64'hBE);
        chk_mod(1, 10, "mod_seg1_kept");

        // Same-cycle collision on controller address 0x40: host wins
        mem_en = 1'b1; mem_we = 1'b1; mem_sel = 2'd0; mem_addr = 14'h40; mem_din = 16'h55AA;
        cnt_we = 1'b1; cnt_addr = 8'h40; cnt_din = 16'h1111;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_we = 1'b0; cnt_we = 1'b0;
        model_write(0, 'h40, 16'h55AA);
        chk_host(0, 'h40, "collide_host");
        chk_cnt('h40, "collide_cnt");
        chk("collide_const", 64'(cnt_dout), 64'h55AA);

        // Non-controller host reads return zero; EN=0 holds and blocks writes
        chk_host(1, 5, "host_rd_mod_zero");
        chk_host(0, 'h40, "host_rd_ctrl");
        mem_en = 1'b0; mem_we = 1'b1; mem_addr = 14'h40; mem_din = 16'h0BAD;
        repeat (3) @(posedge clk);
        #1;
        mem_we = 1'b0;
        chk("en0_hold", 64'(mem_dout), 64'h55AA);
        chk_cnt('h40, "en0_no_write");

        // Cross-port read during write returns old data, then new data
        mem_en = 1'b1; mem_we = 1'b1; mem_sel = 2'd0; mem_addr = 14'h40; mem_din = 16'h9999;
        cnt_addr = 8'h40;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        chk("rdw_old", 64'(cnt_dout), 64'h55AA);
        @(posedge clk); #1;
        model_write(0, 'h40, 16'h9999);
        chk("rdw_new", 64'(cnt_dout), 64'(word_of(0, 'h40)));

        // Reset clears latches, ignores writes, keeps RAM contents
        host_write(0, 'h21, 16'h0001);
        rst = 1'b1;
        mem_en = 1'b1; mem_we = 1'b1; mem_sel = 2'd0; mem_addr = 14'h40; mem_din = 16'hDEAD;
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
        m_mod_seg = 0; m_stm_seg = 0; m_stm_page = 0;
        chk_cnt('h40, "rst_write_ignored");
        host_write(3, 100, 16'hABCD);
        chk_stm(0, 25, 64'hFFFF, "rst_seg0");
        chk_stm(1, 3, '1, "rst_ram_kept");

        // Randomized traffic across all banks and ports
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 4));
            d = 16'($urandom);
            case (kind)
                0: begin
                    a = int'($urandom_range(0, 255));
                    host_write(0, a, d);
                    chk_cnt(a, "rnd_host_to_cnt");
                end
                1: begin
                    a = int'($urandom_range(0, 255));
                    cnt_we = 1'b1; cnt_addr = 8'(a); cnt_din = d;
                    @(posedge clk); #1;
                    cnt_we = 1'b0;
                    ctrl_m[a] = d;
                    chk_host(0, a, "rnd_cnt_to_host");
                end
                2: begin
                    a = int'($urandom_range(0, 16383));
                    host_write(1, a, d);
                    chk_mod(m_mod_seg, 2 * a, "rnd_mod_lo");
                    chk_mod(m_mod_seg, 2 * a + 1, "rnd_mod_hi");
                end
                3: begin
                    a = int'($urandom_range(0, 16383));
                    host_write(2, a, d);
                    chk_duty(2 * a, "rnd_duty_lo");
                    chk_duty(2 * a + 1, "rnd_duty_hi");
                end
                default: begin
                    base = int'($urandom_range(0, 4095)) * 4;
                    for (int k = 0; k < 4; k++) host_write(3, base + k, 16'($urandom));
                    chk_stm(m_stm_seg, (m_stm_page * 16384 + base) / 4, '1, "rnd_stm");
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
